// File: rtl/wb_stage.sv
// Registered writeback stage: selects the result source, waits on variable-latency
// load returns with a timeout, and drives the register-file write port and instret.
module wb_stage #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned HAS_CSR      = 1,
  parameter int unsigned LOAD_TIMEOUT = 15,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] pc_plus4,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  input  logic [1:0]            wb_sel,
  input  logic                  regwrite_in,
  input  logic                  kill_wb,
  input  logic [4:0]            rd_in,
  input  logic                  flush,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_rdata,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  load_err,
  output logic [CNT_WIDTH-1:0]  instret
);

  localparam int unsigned TMO_W = 8;
  // Last WAIT_LOAD cycle index before the load is abandoned.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOAD_TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } state_t;

  state_t                  state_q, state_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [4:0]              hold_rd_q, hold_rd_d;
  logic                    hold_rw_q, hold_rw_d;
  logic                    rf_we_d;
  logic [4:0]              rf_waddr_d;
  logic [DATA_WIDTH-1:0]   rf_wdata_d;
  logic                    load_err_d;
  logic [CNT_WIDTH-1:0]    instret_d;
  logic [DATA_WIDTH-1:0]   csr_src;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    accept;

  assign mem_ready = (state_q == IDLE) && !rst;
  assign accept    = mem_valid && mem_ready;
  assign csr_src   = (HAS_CSR != 0) ? csr_rdata : '0;

  // Non-load result source; wb_sel == 1 never reaches this path.
  always_comb begin
    sel_data = alu_result;
    case (wb_sel)
      2'd2:    sel_data = pc_plus4;
      2'd3:    sel_data = csr_src;
      default: sel_data = alu_result;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    hold_rd_d  = hold_rd_q;
    hold_rw_d  = hold_rw_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr;
    rf_wdata_d = rf_wdata;
    load_err_d = 1'b0;
    instret_d  = instret;

    case (state_q)
      IDLE: begin
        if (accept && !kill_wb) begin
          if (wb_sel == 2'd1) begin
            hold_rd_d = rd_in;
            hold_rw_d = regwrite_in;
            tmo_d     = '0;
            state_d   = WAIT_LOAD;
          end else begin
            rf_we_d    = regwrite_in && (rd_in != 5'd0);
            rf_waddr_d = rd_in;
            rf_wdata_d = sel_data;
            instret_d  = instret + CNT_WIDTH'(1);
          end
        end
      end
      WAIT_LOAD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (load_valid) begin
          rf_we_d    = hold_rw_q && (hold_rd_q != 5'd0);
          rf_waddr_d = hold_rd_q;
          rf_wdata_d = load_rdata;
          instret_d  = instret + CNT_WIDTH'(1);
          state_d    = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          load_err_d = 1'b1;
          state_d    = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      hold_rd_q <= '0;
      hold_rw_q <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      load_err  <= 1'b0;
      instret   <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      hold_rd_q <= hold_rd_d;
      hold_rw_q <= hold_rw_d;
      rf_we     <= rf_we_d;
      rf_waddr  <= rf_waddr_d;
      rf_wdata  <= rf_wdata_d;
      load_err  <= load_err_d;
      instret   <= instret_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: two instances (CSR present / absent) against a transaction-level model.
module tb_wb_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned LT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_valid;
  logic [DW-1:0] alu_result, pc_plus4, csr_rdata, load_rdata;
  logic [1:0]    wb_sel;
  logic          regwrite_in, kill_wb, flush, load_valid;
  logic [4:0]    rd_in;

  logic          mem_ready0, rf_we0, load_err0;
  logic [4:0]    rf_waddr0;
  logic [DW-1:0] rf_wdata0;
  logic [31:0]   instret0;
  logic          mem_ready1, rf_we1, load_err1;
  logic [4:0]    rf_waddr1;
  logic [DW-1:0] rf_wdata1;
  logic [31:0]   instret1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage #(.DATA_WIDTH(DW), .HAS_CSR(1), .LOAD_TIMEOUT(LT), .CNT_WIDTH(32)) dut0 (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready0),
    .alu_result(alu_result), .pc_plus4(pc_plus4), .csr_rdata(csr_rdata),
    .wb_sel(wb_sel), .regwrite_in(regwrite_in), .kill_wb(kill_wb), .rd_in(rd_in),
    .flush(flush), .load_valid(load_valid), .load_rdata(load_rdata),
    .rf_we(rf_we0), .rf_waddr(rf_waddr0), .rf_wdata(rf_wdata0),
    .load_err(load_err0), .instret(instret0));

  wb_stage #(.DATA_WIDTH(DW), .HAS_CSR(0), .LOAD_TIMEOUT(LT), .CNT_WIDTH(32)) dut1 (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready1),
    .alu_result(alu_result), .pc_plus4(pc_plus4), .csr_rdata(csr_rdata),
    .wb_sel(wb_sel), .regwrite_in(regwrite_in), .kill_wb(kill_wb), .rd_in(rd_in),
    .flush(flush), .load_valid(load_valid), .load_rdata(load_rdata),
    .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1),
    .load_err(load_err1), .instret(instret1));

  // Model: an outstanding load with its elapsed wait count, plus the last retired write.
  typedef struct {
    bit          pending;
    int          waited;
    bit [4:0]    rd;
    bit          rw;
    bit          we;
    bit [4:0]    waddr;
    bit [DW-1:0] wdata;
    bit          err;
    bit [31:0]   retired;
  } model_t;

  model_t md0, md1;
  bit     model_ok = 1'b0;

  function automatic model_t model_step(model_t m, bit has_csr);
    model_t n = m;
    n.we  = 1'b0;
    n.err = 1'b0;
    if (rst) begin
      n.pending = 1'b0; n.waited = 0; n.rd = '0; n.rw = 1'b0;
      n.waddr = '0; n.wdata = '0; n.retired = '0;
    end else if (!m.pending) begin
      if (mem_valid && !kill_wb) begin
        if (wb_sel == 2'd1) begin
          n.pending = 1'b1; n.waited = 0; n.rd = rd_in; n.rw = regwrite_in;
        end else begin
          n.we      = regwrite_in && (rd_in != 0);
          n.waddr   = rd_in;
          n.wdata   = (wb_sel == 2'd0) ? alu_result :
                      (wb_sel == 2'd2) ? pc_plus4 : (has_csr ? csr_rdata : '0);
          n.retired = m.retired + 1;
        end
      end
    end else begin
      n.waited = m.waited + 1;
      if (flush) begin
        n.pending = 1'b0;
      end else if (load_valid) begin
        n.pending = 1'b0;
        n.we      = m.rw && (m.rd != 0);
        n.waddr   = m.rd;
        n.wdata   = load_rdata;
        n.retired = m.retired + 1;
      end else if (n.waited >= int'(LT)) begin
        n.pending = 1'b0;
        n.err     = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    md0 <= model_step(md0, 1'b1);
    md1 <= model_step(md1, 1'b0);
    if (rst) model_ok <= 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("m0_ready", 64'(mem_ready0), 64'(!rst && !md0.pending));
      chk("m0_we",    64'(rf_we0),     64'(md0.we));
      chk("m0_waddr", 64'(rf_waddr0),  64'(md0.waddr));
      chk("m0_wdata", 64'(rf_wdata0),  64'(md0.wdata));
      chk("m0_err",   64'(load_err0),  64'(md0.err));
      chk("m0_inst",  64'(instret0),   64'(md0.retired));
      chk("m1_ready", 64'(mem_ready1), 64'(!rst && !md1.pending));
      chk("m1_we",    64'(rf_we1),     64'(md1.we));
      chk("m1_waddr", 64'(rf_waddr1),  64'(md1.waddr));
      chk("m1_wdata", 64'(rf_wdata1),  64'(md1.wdata));
      chk("m1_err",   64'(load_err1),  64'(md1.err));
      chk("m1_inst",  64'(instret1),   64'(md1.retired));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 0; kill_wb = 0; flush = 0; load_valid = 0; regwrite_in = 0;
    wb_sel = 2'd0; rd_in = 5'd0;
  endtask

  initial begin
    rst = 1'b1;
    alu_result = '0; pc_plus4 = '0; csr_rdata = '0; load_rdata = '0;
    idle_inputs();
    step();
    step();
    chk("rst_we", 64'(rf_we0), 64'd0);
    chk("rst_inst", 64'(instret0), 64'd0);
    chk("rst_ready", 64'(mem_ready0), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(mem_ready0), 64'd1);

    // ALU path
    mem_valid = 1; wb_sel = 2'd0; alu_result = 32'hA1A1A1A1; rd_in = 5'd10; regwrite_in = 1;
    step();
    idle_inputs();
    chk("alu_we", 64'(rf_we0), 64'd1);
    chk("alu_waddr", 64'(rf_waddr0), 64'd10);
    chk("alu_wdata", 64'(rf_wdata0), 64'hA1A1A1A1);
    chk("alu_inst", 64'(instret0), 64'd1);

    // Load path, data three cycles after acceptance
    mem_valid = 1; wb_sel = 2'd1; rd_in = 5'd5; regwrite_in = 1;
    step();
    idle_inputs();
    chk("ld_ready0", 64'(mem_ready0), 64'd0);
    chk("ld_we0", 64'(rf_we0), 64'd0);
    step();
    step();
    chk("ld_ready2", 64'(mem_ready0), 64'd0);
    load_valid = 1; load_rdata = 32'hB2B2B2B2;
    step();
    idle_inputs();
    chk("ld_we", 64'(rf_we0), 64'd1);
    chk("ld_waddr", 64'(rf_waddr0), 64'd5);
    chk("ld_wdata", 64'(rf_wdata0), 64'hB2B2B2B2);
    chk("ld_ready", 64'(mem_ready0), 64'd1);
    chk("ld_inst", 64'(instret0), 64'd2);

    // Timeout after LT wait cycles, then late data ignored
    mem_valid = 1; wb_sel = 2'd1; rd_in = 5'd6; regwrite_in = 1;
    step();
    idle_inputs();
    step(); step(); step();
    chk("tmo_err_early", 64'(load_err0), 64'd0);
    chk("tmo_ready_early", 64'(mem_ready0), 64'd0);
    step();
    chk("tmo_err", 64'(load_err0), 64'd1);
    chk("tmo_we", 64'(rf_we0), 64'd0);
    chk("tmo_inst", 64'(instret0), 64'd2);
    load_valid = 1; load_rdata = 32'hEEEEEEEE;
    step();
    idle_inputs();
    chk("tmo_err_once", 64'(load_err0), 64'd0);
    chk("late_we", 64'(rf_we0), 64'd0);
    chk("late_inst", 64'(instret0), 64'd2);

    // Kill and x0
    mem_valid = 1; kill_wb = 1; rd_in = 5'd7; regwrite_in = 1; alu_result = 32'h1234;
    step();
    chk("kill_we", 64'(rf_we0), 64'd0);
    chk("kill_inst", 64'(instret0), 64'd2);
    kill_wb = 0; rd_in = 5'd0;
    step();
    chk("x0_we", 64'(rf_we0), 64'd0);
    chk("x0_waddr", 64'(rf_waddr0), 64'd0);
    chk("x0_inst", 64'(instret0), 64'd3);
    rd_in = 5'd31;
    step();
    chk("r31_we", 64'(rf_we0), 64'd1);
    chk("r31_waddr", 64'(rf_waddr0), 64'd31);
    chk("r31_inst", 64'(instret0), 64'd4);

    // CSR gating on both instances
    wb_sel = 2'd3; csr_rdata = 32'hD4D4D4D4; rd_in = 5'd3;
    step();
    idle_inputs();
    chk("csr_on", 64'(rf_wdata0), 64'hD4D4D4D4);
    chk("csr_off", 64'(rf_wdata1), 64'h0);
    chk("csr_off_we", 64'(rf_we1), 64'd1);

    // flush beats load_valid
    mem_valid = 1; wb_sel = 2'd1; rd_in = 5'd9; regwrite_in = 1;
    step();
    idle_inputs();
    flush = 1; load_valid = 1; load_rdata = 32'h55555555;
    step();
    idle_inputs();
    chk("flush_we", 64'(rf_we0), 64'd0);
    chk("flush_ready", 64'(mem_ready0), 64'd1);
    chk("flush_inst", 64'(instret0), 64'd5);

    // Reset while waiting for a load
    mem_valid = 1; wb_sel = 2'd1; rd_in = 5'd12; regwrite_in = 1;
    step();
    idle_inputs();
    rst = 1;
    step();
    chk("mrst_we", 64'(rf_we0), 64'd0);
    chk("mrst_waddr", 64'(rf_waddr0), 64'd0);
    chk("mrst_wdata", 64'(rf_wdata0), 64'd0);
    chk("mrst_inst", 64'(instret0), 64'd0);
    chk("mrst_ready", 64'(mem_ready0), 64'd0);
    rst = 0;
    #1;
    chk("mrst_ready_after", 64'(mem_ready0), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step();
      rst         = ($urandom_range(0, 299) == 0);
      mem_valid   = ($urandom_range(0, 3) != 0);
      kill_wb     = ($urandom_range(0, 7) == 0);
      wb_sel      = 2'($urandom_range(0, 3));
      regwrite_in = ($urandom_range(0, 4) != 0);
      rd_in       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      flush       = ($urandom_range(0, 15) == 0);
      load_valid  = ($urandom_range(0, 6) == 0);
      alu_result  = $urandom;
      pc_plus4    = $urandom;
      csr_rdata   = $urandom;
      load_rdata  = $urandom;
    end
    step();
    idle_inputs();
    rst = 0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
